// File: rtl/demux_deser_pkg.sv
// rtl/demux_deser_pkg.sv - shared constants and types for the two-channel deserializer
package demux_deser_pkg;

  localparam int W_DEF = 8;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } hold_st_e;

  // Bit counter width; never below 1 so W=2 still gets a real counter.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/demux_deser_if.sv
// rtl/demux_deser_if.sv - serial input, per-channel word outputs and overflow flags
interface demux_deser_if
  import demux_deser_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         din;
  logic         din_valid;
  logic         b;
  logic         y0_ready;
  logic         y1_ready;
  logic         ovf_clr;
  logic [W-1:0] y0;
  logic         y0_valid;
  logic [W-1:0] y1;
  logic         y1_valid;
  logic         ovf0;
  logic         ovf1;

  modport master (
    output din, din_valid, b, y0_ready, y1_ready, ovf_clr,
    input  y0, y0_valid, y1, y1_valid, ovf0, ovf1
  );

  modport slave (
    input  din, din_valid, b, y0_ready, y1_ready, ovf_clr,
    output y0, y0_valid, y1, y1_valid, ovf0, ovf1
  );

endinterface

// File: rtl/demux_deser_chan.sv
// rtl/demux_deser_chan.sv - one channel: LSB-first shifter, bit counter, one-word holding register
module demux_chan
  import demux_deser_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = cnt_w(W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_i,
  input  logic         bit_valid_i,
  input  logic         ready_i,
  input  logic         ovf_clr_i,
  output logic [W-1:0] word_o,
  output logic         valid_o,
  output logic         ovf_o
);

  logic [W-1:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  word_q, word_d;
  hold_st_e      st_q, st_d;
  logic          ovf_q, ovf_d;

  logic complete;
  logic drain;
  logic load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      st_q    <= ST_EMPTY;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      st_q    <= st_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    st_d     = st_q;
    ovf_d    = ovf_q;
    complete = bit_valid_i && (cnt_q == CW'(W - 1));
    drain    = (st_q == ST_FULL) && ready_i;
    load     = complete && ((st_q == ST_EMPTY) || drain);

    if (bit_valid_i) begin
      shift_d[cnt_q] = bit_i;
      cnt_d          = complete ? '0 : CW'(cnt_q + 1'b1);
    end

    // The completed word includes the bit arriving this cycle, so load from shift_d.
    if (load) begin
      word_d = shift_d;
    end

    case (st_q)
      ST_EMPTY: if (load)           st_d = ST_FULL;
      ST_FULL:  if (drain && !load) st_d = ST_EMPTY;
      default:                      st_d = ST_EMPTY;
    endcase

    // A drop in the same cycle as a clear must leave the flag set.
    if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
    if (complete && !load) begin
      ovf_d = 1'b1;
    end
  end

  assign word_o  = word_q;
  assign valid_o = (st_q == ST_FULL);
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/demux_deser.sv
// rtl/demux_deser.sv - routes the serial bit stream by b to two independent deserializing channels
module demux_deser
  import demux_deser_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  demux_deser_if.slave  bus
);

  logic sel0;
  logic sel1;

  assign sel0 = bus.din_valid && (bus.b == CH0);
  assign sel1 = bus.din_valid && (bus.b == CH1);

  demux_chan #(.W(W)) u_chan0 (
    .clk        (clk),
    .rst        (rst),
    .bit_i      (bus.din),
    .bit_valid_i(sel0),
    .ready_i    (bus.y0_ready),
    .ovf_clr_i  (bus.ovf_clr),
    .word_o     (bus.y0),
    .valid_o    (bus.y0_valid),
    .ovf_o      (bus.ovf0)
  );

  demux_chan #(.W(W)) u_chan1 (
    .clk        (clk),
    .rst        (rst),
    .bit_i      (bus.din),
    .bit_valid_i(sel1),
    .ready_i    (bus.y1_ready),
    .ovf_clr_i  (bus.ovf_clr),
    .word_o     (bus.y1),
    .valid_o    (bus.y1_valid),
    .ovf_o      (bus.ovf1)
  );

endmodule

// File: tb/tb_demux_deser.sv
// tb/tb_demux_deser.sv - directed self-checking bench for demux_deser with W=8
module tb_demux_deser;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  demux_deser_if #(.W(8)) bus ();

  demux_deser #(.W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic send_bit(input logic ch, input logic d);
    bus.b         = ch;
    bus.din       = d;
    bus.din_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic send_bits(input logic ch, input logic [7:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send_bit(ch, w[i]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [7:0] e_y0, input logic e_v0,
                             input logic [7:0] e_y1, input logic e_v1,
                             input logic e_o0, input logic e_o1);
    chk({tag, ".y0"},       32'(bus.y0),       32'(e_y0));
    chk({tag, ".y0_valid"}, 32'(bus.y0_valid), 32'(e_v0));
    chk({tag, ".y1"},       32'(bus.y1),       32'(e_y1));
    chk({tag, ".y1_valid"}, 32'(bus.y1_valid), 32'(e_v1));
    chk({tag, ".ovf0"},     32'(bus.ovf0),     32'(e_o0));
    chk({tag, ".ovf1"},     32'(bus.ovf1),     32'(e_o1));
  endtask

  logic [7:0] w3c;
  logic [7:0] wc3;

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.din       = 1'b0;
    bus.din_valid = 1'b0;
    bus.b         = 1'b0;
    bus.y0_ready  = 1'b1;
    bus.y1_ready  = 1'b1;
    bus.ovf_clr   = 1'b0;
    w3c           = 8'h3C;
    wc3           = 8'hC3;

    #12;
    chk_outputs("reset", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Scenario 1: 0xA5 on channel 0, consumed immediately
    send_bits(1'b0, 8'hA5, 0, 6);
    chk("s1.no_early_valid", 32'(bus.y0_valid), 32'd0);
    send_bit(1'b0, 1'b1);
    chk_outputs("s1.word", 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk_outputs("s1.drained", 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Scenario 2: interleave 0x3C on ch0 and 0xC3 on ch1
    for (int i = 0; i < 7; i++) begin
      send_bit(1'b0, w3c[i]);
      send_bit(1'b1, wc3[i]);
    end
    send_bit(1'b0, w3c[7]);
    chk_outputs("s2.ch0", 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, wc3[7]);
    chk_outputs("s2.ch1", 8'h3C, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("s2.y1_drained", 32'(bus.y1_valid), 32'd0);

    // Scenario 3: stalled consumer, second word dropped, then flag cleared
    bus.y0_ready = 1'b0;
    send_bits(1'b0, 8'h11, 0, 7);
    chk_outputs("s3.first", 8'h11, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    send_bits(1'b0, 8'h22, 0, 7);
    chk_outputs("s3.dropped", 8'h11, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    bus.ovf_clr = 1'b1;
    idle(1);
    bus.ovf_clr = 1'b0;
    chk_outputs("s3.cleared", 8'h11, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);

    // Scenario 4: drain and load in the same cycle
    send_bits(1'b0, 8'h22, 0, 6);
    bus.y0_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    chk_outputs("s4.swap", 8'h22, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk_outputs("s4.drained", 8'h22, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);

    // Overflow in the same cycle as ovf_clr keeps the flag set
    bus.y0_ready = 1'b0;
    send_bits(1'b0, 8'h5A, 0, 7);
    send_bits(1'b0, 8'h01, 0, 6);
    bus.ovf_clr = 1'b1;
    send_bit(1'b0, 1'b0);
    bus.ovf_clr = 1'b0;
    chk_outputs("ovf_wins", 8'h5A, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);

    // Scenario 5: reset mid-word on channel 1 discards the partial word
    send_bits(1'b1, 8'h05, 0, 3);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs("s5.async_rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.y0_ready = 1'b1;
    send_bits(1'b1, 8'hFF, 0, 3);
    chk("s5.no_mix_valid", 32'(bus.y1_valid), 32'd0);
    send_bits(1'b1, 8'hFF, 4, 7);
    chk_outputs("s5.word", 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    idle(1);

    // Scenario 6: din_valid low freezes everything regardless of b and din
    bus.y0_ready = 1'b0;
    send_bits(1'b0, 8'h77, 0, 7);
    send_bits(1'b1, 8'h2B, 0, 2);
    for (int i = 0; i < 20; i++) begin
      bus.b   = i[0];
      bus.din = i[1];
      idle(1);
    end
    chk_outputs("s6.frozen", 8'h77, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    send_bits(1'b1, 8'h2B, 3, 7);
    chk_outputs("s6.resume", 8'h77, 1'b1, 8'h2B, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_deser.md
DEMUX_DESER -- requirements
Module: demux_deser

Interface
REQ-001 Parameter W, default 8, serial word width in bits (W >= 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 din  input  1  serial data bit, LSB first.
REQ-005 din_valid  input  1  din and b are sampled only when high.
REQ-006 b  input  1  channel select; 0 routes the bit to channel 0, 1 routes it to channel 1.
REQ-007 y0_ready  input  1  channel-0 consumer accepts y0 when high and y0_valid is high.
REQ-008 y1_ready  input  1  channel-1 consumer accepts y1 when high and y1_valid is high.
REQ-009 ovf_clr  input  1  synchronous clear of both overflow flags.
REQ-010 y0  output  W  channel-0 assembled word.
REQ-011 y0_valid  output  1  y0 holds an unconsumed word.
REQ-012 y1  output  W  channel-1 assembled word.
REQ-013 y1_valid  output  1  y1 holds an unconsumed word.
REQ-014 ovf0  output  1  sticky flag: a channel-0 word was dropped.
REQ-015 ovf1  output  1  sticky flag: a channel-1 word was dropped.

Function
REQ-016 Each channel SHALL have an independent shift register, a bit counter of width clog2(W), and a one-word holding register.
REQ-017 When din_valid=1, the block SHALL shift din into the channel selected by b at counter position cnt (LSB first) and increment that channel's counter; the other channel SHALL be unchanged.
REQ-018 When din_valid=0, no shift register or counter SHALL change; b SHALL be ignored.
REQ-019 On the W-th accepted bit (cnt = W-1), the counter SHALL wrap to 0 and the completed word SHALL be offered to the holding register in the same cycle.
REQ-020 The holding register SHALL load the word if it is empty or is being drained in that cycle (yN_valid & yN_ready); yN_valid SHALL be 1 from the next cycle. Latency from the W-th bit's edge to yN_valid is one cycle.
REQ-021 Simultaneous drain and load SHALL keep yN_valid=1 with the new word, with no bubble.
REQ-022 If a word completes while the holding register is full and not being drained, the word SHALL be dropped, the held word SHALL be retained, and ovfN SHALL set on the next edge.
REQ-023 A drain without a load SHALL clear yN_valid on the next edge; yN SHALL retain its last value.
REQ-024 yN and yN_valid SHALL NOT change while yN_valid=1 and yN_ready=0, except as stated in REQ-021.
REQ-025 The per-channel state machine SHALL have two states. EMPTY goes to FULL on load. FULL goes to EMPTY on drain without load, and otherwise stays FULL.
REQ-026 ovf_clr=1 SHALL clear ovf0 and ovf1. A new overflow in the same cycle SHALL win, and the affected flag SHALL be 1.

Reset
REQ-027 rst=1 SHALL asynchronously force to 0: y0, y1, y0_valid, y1_valid, ovf0, ovf1, both counters and both shift registers.
REQ-028 rst asserted mid-word SHALL discard partial words. After release, the next accepted bit SHALL be bit 0 of a new word.
REQ-029 The first rising clk edge after rst falls SHALL be a normal operating edge.

Structure
REQ-030 The default W, the channel encodings (CH0=0, CH1=1) and the counter width SHALL live in a shared constants include file.
REQ-031 The per-channel logic (shift, counter, holding register, overflow) SHALL be one sub-module, demux_chan, instantiated twice. The top level SHALL contain only routing of din_valid by b.

Verification
REQ-032 Scenario 1: W=8; send 0xA5 LSB first with b=0, y0_ready=1 -> y0=0xA5, y0_valid=1 for one cycle, one cycle after the 8th bit; y1_valid stays 0.
REQ-033 Scenario 2: interleave bits of 0x3C (b=0) and 0xC3 (b=1) bit by bit -> y0=0x3C and y1=0xC3, each valid one cycle after its own 8th bit.
REQ-034 Scenario 3: y0_ready=0; send 0x11 then 0x22 on channel 0 -> y0 stays 0x11 and ovf0=1; pulse ovf_clr -> ovf0=0 and y0 is still 0x11.
REQ-035 Scenario 4: y0 holds 0x11; assert y0_ready in the same cycle 0x22 completes -> y0=0x22, y0_valid stays 1, ovf0=0.
REQ-036 Scenario 5: send 4 bits on channel 1, assert rst, then send 0xFF -> y1=0xFF, not a mixture of old and new bits.
REQ-037 Scenario 6: toggle b and din with din_valid=0 for 20 cycles -> no counter, output or flag changes.
